// File: rtl/display_pkg.sv
// Shared constants and types for the four-tube multiplexed seven-segment display.
// Segment vectors are ordered gfedcba and are active-low (0 lights a segment).
package display_pkg;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [3:0] TUBE_OFF  = 4'b1111;

   // Digit table, element [n] is the pattern for BCD value n
   localparam logic [9:0][6:0] SEG_DIGITS = {
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   // Active-low one-hot tube select for a slot index
   function automatic logic [3:0] tube_sel(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/display_scan_seg7_decode.sv
// Combinational BCD to seven-segment decoder, active-low gfedcba.
// Codes 10-15 are not decimal digits and show a dash.
module seg7_decode
   import display_pkg::*;
(
   input  bcd_t       i_bcd,
   output logic [6:0] o_seg
);

   // Table lookup for 0-9, dash for the illegal codes
   always_comb begin
      o_seg = SEG_DASH;
      if (i_bcd <= 4'd9) o_seg = SEG_DIGITS[i_bcd];
   end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed seven-segment scanner.
// Each digit slot lasts PRESCALE cycles; its first cycle is a blank gap so the
// previous digit's segments never ghost onto the next tube. New values are
// loaded into a pending register and only become visible at the frame boundary.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module display_scan
   import display_pkg::*;
#(
   parameter int PRESCALE = 4
)(
   input  logic        clock_50H,
   input  logic        reset,
   input  logic [15:0] digit_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  tube,
   output logic        frame_start
);

   localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [15:0]   r_pend_dig;
   logic [3:0]    r_pend_dp;
   logic [15:0]   r_act_dig;
   logic [3:0]    r_act_dp;

   logic          w_last;
   logic          w_commit;
   bcd_t          w_cur_bcd;
   logic [6:0]    w_seg_raw;
   logic [6:0]    w_seg;

   assign w_last    = (r_cnt == CW'(PRESCALE - 1));
   assign w_commit  = w_last && (r_idx == 2'd3);
   assign w_cur_bcd = r_act_dig[{r_idx, 2'b00} +: 4];

   seg7_decode u_dec (
      .i_bcd (w_cur_bcd),
      .o_seg (w_seg_raw)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic [3:0] w_zero;
   logic       w_blank;

   assign w_zero = {r_act_dig[15:12] == 4'd0, r_act_dig[11:8] == 4'd0,
                    r_act_dig[7:4]   == 4'd0, r_act_dig[3:0]  == 4'd0};

   // A digit is a leading zero when it and every more significant digit are
   // zero; the units digit always shows so a value of zero reads "0".
   always_comb begin
      w_blank = 1'b0;
      case (r_idx)
         2'd3:    w_blank = w_zero[3];
         2'd2:    w_blank = w_zero[3] & w_zero[2];
         2'd1:    w_blank = w_zero[3] & w_zero[2] & w_zero[1];
         default: w_blank = 1'b0;
      endcase
   end

   assign w_seg = w_blank ? SEG_BLANK : w_seg_raw;
`else
   assign w_seg = w_seg_raw;
`endif

   // Slot timing: prescaler within a slot, slot index advancing on its wrap
   always_ff @(posedge clock_50H) begin
      if (reset) begin
         r_cnt <= '0;
         r_idx <= 2'd0;
      end else if (w_last) begin
         r_cnt <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Pending capture on load; active copy only at the frame boundary so a
   // frame never mixes old and new digits. A load on the boundary itself
   // goes straight through so it is not delayed by a whole frame.
   always_ff @(posedge clock_50H) begin
      if (reset) begin
         r_pend_dig <= '0;
         r_pend_dp  <= '0;
         r_act_dig  <= '0;
         r_act_dp   <= '0;
      end else begin
         if (load) begin
            r_pend_dig <= digit_in;
            r_pend_dp  <= dp_in;
         end
         if (w_commit) begin
            r_act_dig <= load ? digit_in : r_pend_dig;
            r_act_dp  <= load ? dp_in    : r_pend_dp;
         end
      end
   end

   // Registered drive: blank gap on the first cycle of each slot, else the digit
   always_ff @(posedge clock_50H) begin
      if (reset) begin
         tube        <= TUBE_OFF;
         seg         <= SEG_BLANK;
         dp          <= 1'b1;
         frame_start <= 1'b0;
      end else if (r_cnt == '0) begin
         tube        <= TUBE_OFF;
         seg         <= SEG_BLANK;
         dp          <= 1'b1;
         frame_start <= (r_idx == 2'd0);
      end else begin
         tube        <= tube_sel(r_idx);
         seg         <= w_seg;
         dp          <= ~r_act_dp[r_idx];
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan (PRESCALE=4). A behavioural frame model
// predicts every output cycle through a scoreboard queue; a vector table checks
// whole frames of decoded digits; hand sequences cover reset and commit timing.
module tb_display_scan;

   localparam int P  = 4;
   localparam int FR = 4 * P;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] ZL = 7'h7F;
`else
   localparam logic [6:0] ZL = 7'b1000000;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] digit_in;
   logic [3:0]  dp_in;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  tube;
   logic        frame_start;

   always #5 clk = ~clk;

   display_scan #(.PRESCALE(P)) dut (
      .clock_50H   (clk),
      .reset       (reset),
      .digit_in    (digit_in),
      .dp_in       (dp_in),
      .load        (load),
      .seg         (seg),
      .dp          (dp),
      .tube        (tube),
      .frame_start (frame_start)
   );

   typedef struct packed {
      logic [3:0] tube;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
   } obs_t;

   typedef struct {
      logic [15:0]     d;
      logic [3:0]      p;
      int              ld_pos;
      logic [3:0][6:0] s;      // expected seg per slot, {slot3..slot0}
      logic [3:0]      edp;    // expected dp pin per slot
   } vec_t;

   obs_t        exp_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_fs = -1;
   int          m_pos = 0;
   logic [15:0] m_pd = '0, m_ad = '0;
   logic [3:0]  m_pp = '0, m_ap = '0;
   logic [6:0]  snap_seg [4];
   logic        snap_dp  [4];
   vec_t        tbl [5];

   function automatic logic [6:0] ref_seg(input logic [3:0] b);
      case (b)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic obs_t model_out(input logic rst);
      obs_t o;
      int s, ph;
      o = '{tube: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
      if (!rst) begin
         s  = m_pos / P;
         ph = m_pos % P;
         if (ph == 0) o.fs = (s == 0);
         else begin
            o.tube    = 4'hF;
            o.tube[s] = 1'b0;
            o.seg     = ref_seg(m_ad[s*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (s > 0 && (m_ad >> (4 * s)) == 16'h0) o.seg = 7'h7F;
`endif
            o.dp      = ~m_ap[s];
         end
      end
      return o;
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, predict, advance model, compare
   task automatic step(input logic rst, input logic ld, input logic [15:0] d, input logic [3:0] p);
      obs_t       e;
      logic [3:0] sel;
      reset = rst; load = ld; digit_in = d; dp_in = p;
      exp_q.push_back(model_out(rst));
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_pos = 0; m_pd = '0; m_pp = '0; m_ad = '0; m_ap = '0;
         last_fs = -1;
      end else begin
         if (ld) begin m_pd = d; m_pp = p; end
         if (m_pos == FR - 1) begin m_ad = m_pd; m_ap = m_pp; end
         m_pos = (m_pos + 1) % FR;
      end
      #1;
      e = exp_q.pop_front();
      check("tube", 32'(tube), 32'(e.tube));
      check("seg", 32'(seg), 32'(e.seg));
      check("dp", 32'(dp), 32'(e.dp));
      check("frame_start", 32'(frame_start), 32'(e.fs));
      if (frame_start === 1'b1) begin
         if (last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'(FR));
         last_fs = cyc;
      end
      for (int i = 0; i < 4; i++) begin
         sel = ~(4'b0001 << i);
         if (tube === sel) begin snap_seg[i] = seg; snap_dp[i] = dp; end
      end
      load = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
   endtask

   task automatic run_to(input int target);
      for (int k = 0; k < FR && m_pos != target; k++) idle();
      check("run_to_reached", 32'(m_pos), 32'(target));
   endtask

   task automatic clear_snap();
      for (int i = 0; i < 4; i++) begin snap_seg[i] = 7'h55; snap_dp[i] = 1'bx; end
   endtask

   task automatic capture_frame();
      run_to(0);
      clear_snap();
      repeat (FR) idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [6:0] prev3;

      tbl[0] = '{d: 16'h1208, p: 4'b0100, ld_pos: 2,
                 s: {7'b1111001, 7'b0100100, 7'b1000000, 7'b0000000}, edp: 4'b1011};
      tbl[1] = '{d: 16'h0001, p: 4'b0000, ld_pos: 5,
                 s: {ZL, ZL, ZL, 7'b1111001}, edp: 4'b1111};
      tbl[2] = '{d: 16'h0050, p: 4'b0001, ld_pos: 2,
                 s: {ZL, ZL, 7'b0010010, 7'b1000000}, edp: 4'b1110};
      tbl[3] = '{d: 16'h9763, p: 4'b1000, ld_pos: 7,
                 s: {7'b0010000, 7'b1111000, 7'b0000010, 7'b0110000}, edp: 4'b0111};
      tbl[4] = '{d: 16'h00AF, p: 4'b0011, ld_pos: FR - 1,
                 s: {ZL, ZL, 7'b0111111, 7'b0111111}, edp: 4'b1100};

      reset = 1'b1; load = 1'b0; digit_in = '0; dp_in = '0;
      clear_snap();

      // Reset held three cycles with loads attempted: outputs stay blank
      repeat (3) step(1'b1, 1'b1, 16'h8888, 4'hF);
      check("rst_tube", 32'(tube), 32'h0000000F);
      check("rst_seg", 32'(seg), 32'h0000007F);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_fs", 32'(frame_start), 32'h0);

      // First cycle after release behaves as slot 0 gap
      idle();
      check("fs_after_release", 32'(frame_start), 32'h1);
      check("gap_after_release", 32'(tube), 32'h0000000F);

      // Vector table: load mid-frame (or on commit), the old frame finishes,
      // the next frame shows the new value
      prev3 = ZL;
      for (int v = 0; v < 5; v++) begin
         clear_snap();
         run_to(tbl[v].ld_pos);
         step(1'b0, 1'b1, tbl[v].d, tbl[v].p);
         run_to(0);
         check($sformatf("old_frame_slot3_v%0d", v), 32'(snap_seg[3]), 32'(prev3));
         capture_frame();
         for (int i = 0; i < 4; i++) begin
            check($sformatf("frame_seg_v%0d_d%0d", v, i), 32'(snap_seg[i]), 32'(tbl[v].s[i]));
            check($sformatf("frame_dp_v%0d_d%0d", v, i), 32'(snap_dp[i]), 32'(tbl[v].edp[i]));
         end
         prev3 = tbl[v].s[3];
      end

      // Two loads before one commit: the later one wins
      run_to(3);
      step(1'b0, 1'b1, 16'h1111, 4'hF);
      run_to(9);
      step(1'b0, 1'b1, 16'h2468, 4'h0);
      capture_frame();
      check("last_load_wins_d0", 32'(snap_seg[0]), 32'(7'b0000000));
      check("last_load_wins_d3", 32'(snap_seg[3]), 32'(7'b0100100));
      check("last_load_wins_dp", 32'(snap_dp[1]), 32'h1);

      // Reset during slot 2 with a pending load: frame abandoned, pending lost
      run_to(0);
      run_to(9);
      step(1'b0, 1'b1, 16'h4321, 4'hF);
      step(1'b1, 1'b0, 16'h0, 4'h0);
      check("midrst_tube", 32'(tube), 32'h0000000F);
      check("midrst_seg", 32'(seg), 32'h0000007F);
      step(1'b1, 1'b0, 16'h0, 4'h0);
      idle();
      check("midrst_fs_after_release", 32'(frame_start), 32'h1);
      capture_frame();
      check("midrst_d0", 32'(snap_seg[0]), 32'(7'b1000000));
      check("midrst_d1", 32'(snap_seg[1]), 32'(ZL));
      check("midrst_d2", 32'(snap_seg[2]), 32'(ZL));
      check("midrst_d3", 32'(snap_seg[3]), 32'(ZL));
      for (int i = 0; i < 4; i++)
         check($sformatf("midrst_dp_d%0d", i), 32'(snap_dp[i]), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
